// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Purpose : Items shared by the adder block and its bench.
//           - ADDER_DEFAULT_WIDTH : default operand width in bits.
//           - adder_txn_t         : one transaction (operands, valid flag and
//                                   the full-width sum the block must return).
// Ports   : none (package).
// -----------------------------------------------------------------------------
package adder_pkg;

   localparam int ADDER_DEFAULT_WIDTH = 32;

   // Transaction record: expected_sum is one bit wider so the carry is kept.
   typedef struct packed {
      logic [ADDER_DEFAULT_WIDTH-1:0] a;
      logic [ADDER_DEFAULT_WIDTH-1:0] b;
      logic                           valid;
      logic [ADDER_DEFAULT_WIDTH:0]   expected_sum;
   } adder_txn_t;

endpackage : adder_pkg

// File: rtl/adder_intf.sv
// -----------------------------------------------------------------------------
// adder_intf
// Purpose : Signal bundle between the adder block and its environment.
// Ports   : clk   - single clock, rising-edge active
//           rst   - synchronous active-high reset
// Signals : a, b       - WIDTH-bit unsigned operands
//           valid      - a and b meaningful this cycle
//           sum        - WIDTH+1-bit registered result, carry in MSB
//           sum_valid  - sum was loaded on the last rising edge
// Modports: DUT (block side), TB (environment side).
// -----------------------------------------------------------------------------
interface adder_intf
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_DEFAULT_WIDTH
) (
   input logic clk,
   input logic rst
);

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             valid;
   logic [WIDTH:0]   sum;
   logic             sum_valid;

   clocking cb @(posedge clk);
      output a, b, valid;
      input  sum, sum_valid;
   endclocking

   modport DUT (
      input  clk, rst, a, b, valid,
      output sum, sum_valid
   );

   // clk and rst are ports of the interface itself, so the environment
   // side observes them; everything else is reversed relative to DUT.
   modport TB (
      input  clk, rst, sum, sum_valid,
      output a, b, valid
   );

endinterface : adder_intf

// File: rtl/adder_core.sv
// -----------------------------------------------------------------------------
// adder_core
// Purpose : Purely combinational unsigned add, full width (no truncation).
// Ports   : i_a   [WIDTH-1:0] - operand A
//           i_b   [WIDTH-1:0] - operand B
//           o_sum [WIDTH:0]   - i_a + i_b, carry in MSB
// -----------------------------------------------------------------------------
module adder_core
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH:0]   o_sum
);

   // Zero-extend both operands so the carry lands in the extra MSB.
   always_comb begin
      o_sum = {1'b0, i_a} + {1'b0, i_b};
   end

endmodule : adder_core

// File: rtl/adder.sv
// -----------------------------------------------------------------------------
// adder
// Purpose : One-cycle-latency registered unsigned adder, one result per cycle,
//           no backpressure. The add itself lives in adder_core; this level
//           holds only the output registers (and optional assertions).
// Ports   : bus (adder_intf.DUT)
//             clk, rst, a, b, valid  - inputs
//             sum, sum_valid         - registered outputs
// Config  : define ADDER_ASSERT_EN to compile the concurrent assertions;
//           without it no assertion code is built and function is identical.
// -----------------------------------------------------------------------------
module adder
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_DEFAULT_WIDTH
) (
   adder_intf.DUT bus
);

   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] r_sum;
   logic           r_sum_valid;

   adder_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .i_a   (bus.a),
      .i_b   (bus.b),
      .o_sum (w_sum)
   );

   // Output registers: load on valid, hold sum otherwise; reset clears both.
   always_ff @(posedge bus.clk) begin
      if (bus.rst) begin
         r_sum       <= {(WIDTH+1){1'b0}};
         r_sum_valid <= 1'b0;
      end else if (bus.valid) begin
         r_sum       <= w_sum;
         r_sum_valid <= 1'b1;
      end else begin
         r_sum       <= r_sum;
         r_sum_valid <= 1'b0;
      end
   end

   assign bus.sum       = r_sum;
   assign bus.sum_valid = r_sum_valid;

`ifdef ADDER_ASSERT_EN
   // Operands must be fully known whenever they are consumed.
   ap_no_x : assert property (@(posedge bus.clk)
      (bus.valid && !bus.rst) |-> !$isunknown({bus.a, bus.b}));

   // A flagged result equals the operands presented one edge earlier.
   ap_sum : assert property (@(posedge bus.clk) disable iff (bus.rst)
      bus.sum_valid |-> (bus.sum == ({1'b0, $past(bus.a)} + {1'b0, $past(bus.b)})));

   // Without a load (and not just out of reset) the result must not move.
   ap_hold : assert property (@(posedge bus.clk) disable iff (bus.rst)
      (!bus.sum_valid && !$past(bus.rst)) |-> $stable(bus.sum));
`else
`endif

endmodule : adder

// File: tb/tb_adder.sv
// -----------------------------------------------------------------------------
// tb_adder
// Purpose : Self-checking bench for adder. Inputs change on the falling edge,
//           the block samples on the rising edge, outputs are compared on the
//           next falling edge against a queue-based scoreboard plus literal
//           expectations for the directed scenarios.
// -----------------------------------------------------------------------------
module tb_adder;
   import adder_pkg::*;

   localparam int W = 32;

   logic clk;
   logic rst;

   int errors = 0;
   int checks = 0;

   adder_intf #(.WIDTH(W)) intf (.clk(clk), .rst(rst));

   adder #(.WIDTH(W)) u_dut (.bus(intf));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   adder_txn_t     sb[$];
   logic           m_valid = 1'b0;
   logic [W:0]     m_hold  = '0;

   // Model: at each rising edge, record what the block was asked to do.
   always @(posedge clk) begin
      adder_txn_t t;
      if (rst) begin
         sb.delete();
         m_valid = 1'b0;
         m_hold  = '0;
      end else if (intf.valid) begin
         t.a            = intf.a;
         t.b            = intf.b;
         t.valid        = 1'b1;
         t.expected_sum = (W+1)'(longint'(intf.a) + longint'(intf.b));
         sb.push_back(t);
         m_valid = 1'b1;
      end else begin
         m_valid = 1'b0;
      end
   end

   // Compare process: every falling edge the outputs must match the model.
   always @(negedge clk) begin
      adder_txn_t t;
      checks++;
      if (m_valid) begin
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: scoreboard empty while a result was expected");
         end else begin
            t = sb.pop_front();
            if (intf.sum !== t.expected_sum || intf.sum_valid !== 1'b1) begin
               errors++;
               $display("FAIL sb_result: a=%0d b=%0d got sum=%0h sv=%0b want sum=%0h sv=1",
                        t.a, t.b, intf.sum, intf.sum_valid, t.expected_sum);
            end
            m_hold = t.expected_sum;
         end
      end else begin
         if (intf.sum !== m_hold || intf.sum_valid !== 1'b0) begin
            errors++;
            $display("FAIL sb_idle: got sum=%0h sv=%0b want sum=%0h sv=0",
                     intf.sum, intf.sum_valid, m_hold);
         end
      end
   end

   // Drive one cycle of inputs, then wait until the following falling edge.
   task automatic cyc(input logic r, input logic v, input logic [W-1:0] aa,
                      input logic [W-1:0] bb);
      rst        = r;
      intf.valid = v;
      intf.a     = aa;
      intf.b     = bb;
      @(negedge clk);
   endtask

   // Literal check of sum and sum_valid.
   task automatic chk(input string name, input logic [W:0] want_sum,
                      input logic want_sv);
      checks++;
      if (intf.sum !== want_sum || intf.sum_valid !== want_sv) begin
         errors++;
         $display("FAIL %s: got sum=%0h sv=%0b want sum=%0h sv=%0b",
                  name, intf.sum, intf.sum_valid, want_sum, want_sv);
      end
   endtask

   initial begin
      rst        = 1'b1;
      intf.valid = 1'b0;
      intf.a     = '0;
      intf.b     = '0;

      // Reset for two cycles with valid low
      cyc(1'b1, 1'b0, 32'd0, 32'd0);
      chk("reset_c1", 33'd0, 1'b0);
      cyc(1'b1, 1'b0, 32'd0, 32'd0);
      chk("reset_c2", 33'd0, 1'b0);

      // Simple add
      cyc(1'b0, 1'b1, 32'd100, 32'd55);
      chk("add_100_55", 33'd155, 1'b1);

      // All-ones boundary, carry out
      cyc(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("max_operands", 33'h1_FFFF_FFFE, 1'b1);

      // All-zeros boundary
      cyc(1'b0, 1'b1, 32'd0, 32'd0);
      chk("zero_operands", 33'd0, 1'b1);

      // Hold when valid drops
      cyc(1'b0, 1'b1, 32'd7, 32'd8);
      chk("add_7_8", 33'd15, 1'b1);
      cyc(1'b0, 1'b0, 32'd1, 32'd1);
      chk("hold_15_a", 33'd15, 1'b0);
      cyc(1'b0, 1'b0, 32'd1, 32'd1);
      chk("hold_15_b", 33'd15, 1'b0);

      // Back-to-back stream, no bubbles
      for (int i = 1; i <= 10; i++) begin
         cyc(1'b0, 1'b1, 32'(i), 32'(2 * i));
         chk($sformatf("stream_%0d", i), 33'(3 * i), 1'b1);
      end

      // Reset in the middle of a stream
      cyc(1'b0, 1'b1, 32'd200, 32'd50);
      chk("pre_rst_250", 33'd250, 1'b1);
      cyc(1'b1, 1'b1, 32'd200, 32'd50);
      chk("mid_rst", 33'd0, 1'b0);
      cyc(1'b0, 1'b1, 32'd200, 32'd50);
      chk("post_rst_250", 33'd250, 1'b1);

      // Random transactions, checked by the scoreboard process
      for (int n = 0; n < 60; n++) begin
         cyc(1'b0, 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)));
      end

      // Idle tail so the last result is compared
      cyc(1'b0, 1'b0, 32'd0, 32'd0);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_adder
